rand_range_sampler: RTL

// - Consumes the free-running 64-bit LFSR state (four 16-bit lanes, advancing every clk) and turns it into a

---
 rtl/rand_pkg.sv | 34 +++
 rtl/rand_fifo.sv | 76 +++++++
 rtl/rand_range_sampler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rand_pkg.sv
// Shared definitions for the range sampler slice.
//
// Contents:
//   LANES, LANE_W - geometry of the incoming LFSR state (4 lanes x 16 bits)
//   state_t       - sampler FSM states (IDLE, WARM, RUN)
//   mask_for()    - rejection mask for a given range bound
package rand_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Smallest all-ones mask covering limit-1. This is done by smearing the
    // top set bit of (limit-1) downward. A bound of 0 selects the full 16-bit
    // range. A bound of 1 yields mask 0, so every sample collapses to 0.
    function automatic logic [LANE_W-1:0] mask_for(input logic [LANE_W-1:0] limit);
        logic [LANE_W-1:0] v;
        v = limit - 16'd1;
        v = v | (v >> 1);
        v = v | (v >> 2);
        v = v | (v >> 4);
        v = v | (v >> 8);
        if (limit == '0) begin
            v = '1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rand_fifo.sv
// Small synchronous FIFO holding accepted samples.
//
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   wr_en      - push wr_data (ignored when full)
//   wr_data    - sample to push
//   rd_en      - pop head (ignored when empty)
//   flush      - empty the FIFO this edge, overriding push/pop
//   full       - DEPTH entries held (evaluated before any same-cycle pop)
//   empty      - no entries held
//   head       - oldest entry, stable until popped
module rand_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Full is taken before the pop, so a push into a full FIFO is refused
    // even if the consumer drains an entry on the same edge.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage, pointers and occupancy. Storage is cleared on reset so the
    // head reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + (AW + 1)'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/rand_range_sampler.sv
// Turns the free-running 64-bit LFSR state into uniform integers in
// [0, limit) by mask-and-reject sampling. Accepted samples are buffered in a
// small FIFO and delivered over a valid/ready handshake. After reset,
// re-enable or reconfiguration, WARMUP cycles are discarded before sampling.
//
// Optional feature: define RAND_SAMPLER_STATS_EN to add the rej_cnt port.
//
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   en          - sampling enable; low forces IDLE (buffered samples kept)
//   rnd_in      - LFSR state, lane i = rnd_in[16i+15:16i]
//   cfg_limit   - range bound, 0 = full 16-bit range
//   cfg_load    - strobe: latch cfg_limit, flush FIFO, re-warm
//   out_data    - head sample, valid when out_valid
//   out_valid   - FIFO not empty
//   out_ready   - consumer accepts when out_valid && out_ready
//   busy        - sampler is not in RUN
//   rej_cnt     - (RAND_SAMPLER_STATS_EN only) saturating count of cycles
//                 in which all four lanes were rejected
module rand_range_sampler
    import rand_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WARMUP = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [LANES*LANE_W-1:0] rnd_in,
    input  logic [LANE_W-1:0]       cfg_limit,
    input  logic                    cfg_load,
    output logic [LANE_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
`ifdef RAND_SAMPLER_STATS_EN
    ,
    output logic [LANE_W-1:0]       rej_cnt
`endif
);

    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP - 1);

    state_t            state;
    logic [LANE_W-1:0] limit_q;
    logic [LANE_W-1:0] mask_q;
    logic [1:0]        lane_ptr;
    logic [WCW-1:0]    warm_cnt;

    logic [LANE_W-1:0] lanes [LANES];
    logic [1:0]        idx;
    logic              hit;
    logic [1:0]        hit_lane;
    logic [LANE_W-1:0] hit_data;
    logic              run_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic              wr;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lanes[g] = rnd_in[g*LANE_W +: LANE_W];
    end

    // Round-robin scan starting at lane_ptr: the first lane whose masked
    // value falls below the bound wins. A zero bound accepts everything.
    always_comb begin
        hit      = 1'b0;
        hit_lane = lane_ptr;
        hit_data = '0;
        idx      = lane_ptr;
        for (int k = 0; k < LANES; k++) begin
            idx = lane_ptr + 2'(k);
            if (!hit && ((limit_q == '0) || ((lanes[idx] & mask_q) < limit_q))) begin
                hit      = 1'b1;
                hit_lane = idx;
                hit_data = lanes[idx] & mask_q;
            end
        end
    end

    // A reconfiguration strobe or a dropped enable suppresses the write.
    assign run_ok = (state == RUN) && en && !cfg_load;
    assign wr     = run_ok && hit && !fifo_full;

    // Sampler FSM. cfg_load outranks everything but reset; a low enable
    // parks the FSM in IDLE without touching the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b1;
            limit_q  <= '0;
            mask_q   <= 16'hFFFF;
            lane_ptr <= '0;
            warm_cnt <= '0;
        end else if (cfg_load) begin
            limit_q  <= cfg_limit;
            mask_q   <= mask_for(cfg_limit);
            warm_cnt <= '0;
            busy     <= 1'b1;
            state    <= en ? WARM : IDLE;
        end else if (!en) begin
            state <= IDLE;
            busy  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state    <= WARM;
                    warm_cnt <= '0;
                end
                WARM: begin
                    warm_cnt <= warm_cnt + WCW'(1);
                    if (warm_cnt == WARM_LAST) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (wr) begin
                        lane_ptr <= hit_lane + 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    rand_fifo #(
        .DEPTH (DEPTH),
        .W     (LANE_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr),
        .wr_data (hit_data),
        .rd_en   (out_valid && out_ready),
        .flush   (cfg_load),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (out_data)
    );

    assign out_valid = !fifo_empty;

`ifdef RAND_SAMPLER_STATS_EN
    logic [LANE_W-1:0] rej_q;

    // Counts sampling opportunities that were lost purely to rejection,
    // not to a full FIFO. Saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset || cfg_load) begin
            rej_q <= '0;
        end else if (run_ok && !fifo_full && !hit && (rej_q != 16'hFFFF)) begin
            rej_q <= rej_q + 16'd1;
        end
    end

    assign rej_cnt = rej_q;
`endif

endmodule
